// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline hazard/stall control slice:
// mult/div state encoding, default latencies and the stall-control bundle.
package mips_pipe_pkg;

    localparam int unsigned DEF_MULT_LAT = 4;
    localparam int unsigned DEF_DIV_LAT  = 32;
    localparam int unsigned DEF_CNT_W    = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [0:0] MD_IDLE = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN = '{
        pc_write:    1'b1,
        if_id_write: 1'b1,
        if_id_flush: 1'b0,
        id_ex_flush: 1'b0
    };

    localparam ctrl_t CTRL_RESET = '{
        pc_write:    1'b0,
        if_id_write: 1'b0,
        if_id_flush: 1'b1,
        id_ex_flush: 1'b1
    };

    localparam ctrl_t CTRL_BRANCH = '{
        pc_write:    1'b1,
        if_id_write: 1'b1,
        if_id_flush: 1'b1,
        id_ex_flush: 1'b1
    };

    localparam ctrl_t CTRL_STALL = '{
        pc_write:    1'b0,
        if_id_write: 1'b0,
        if_id_flush: 1'b0,
        id_ex_flush: 1'b1
    };

    localparam ctrl_t CTRL_JUMP = '{
        pc_write:    1'b1,
        if_id_write: 1'b1,
        if_id_flush: 1'b1,
        id_ex_flush: 1'b0
    };

    // Wide enough to hold the larger latency minus one; never below 1 bit.
    function automatic int unsigned cnt_width(
        input int unsigned a,
        input int unsigned b
    );
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/md_latency_counter.sv
// HI/LO unit occupancy tracker: two-state FSM plus a down-counter that
// is loaded with the op latency minus one when a mult/div issues.
module md_latency_counter
    import mips_pipe_pkg::*;
#(
    parameter int unsigned MULT_LAT = DEF_MULT_LAT,
    parameter int unsigned DIV_LAT  = DEF_DIV_LAT
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int unsigned CW = cnt_width(MULT_LAT, DIV_LAT);

    localparam logic [CW-1:0] MULT_LD = CW'(MULT_LAT - 1);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_LAT - 1);

    logic [0:0]    state;
    logic [0:0]    state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          done;

    assign done = (state == MD_BUSY) && (cnt == '0);
    assign busy = (state == MD_BUSY);

    // A new issue always wins, so a busy unit simply restarts.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (start) begin
            state_nx = MD_BUSY;
            cnt_nx   = is_div ? DIV_LD : MULT_LD;
        end else if (state == MD_BUSY) begin
            if (done) begin
                state_nx = MD_IDLE;
            end else begin
                cnt_nx = cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS pipeline: load-use and
// HI/LO bubbles, branch/jump flushes, and a saturating stall counter.
module hazard_stall_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int unsigned MULT_LAT = DEF_MULT_LAT,
    parameter int unsigned DIV_LAT  = DEF_DIV_LAT,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic             ID_ReadsHiLo,
    input  logic             ID_Jump,
    input  logic             EX_MemtoReg,
    input  logic [4:0]       EX_Rt,
    input  logic             EX_BranchTkn,
    input  logic             EX_MdStart,
    input  logic             EX_MdIsDiv,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             Md_Busy,
    output logic [CNT_W-1:0] Stall_Cnt
);

    logic  rs_hit;
    logic  rt_hit;
    logic  load_use;
    logic  hilo_use;
    logic  stall;
    logic  md_busy;
    ctrl_t ctrl;

    md_latency_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_cnt (
        .clk    (clk),
        .reset  (Reset),
        .start  (EX_MdStart),
        .is_div (EX_MdIsDiv),
        .busy   (md_busy)
    );

    // Masked during reset so the unit never looks busy before the edge lands.
    assign Md_Busy = md_busy && !Reset;

    assign rs_hit   = ID_UsesRs && (ID_Rs == EX_Rt);
    assign rt_hit   = ID_UsesRt && (ID_Rt == EX_Rt);
    assign load_use = EX_MemtoReg && (EX_Rt != REG_ZERO) && (rs_hit || rt_hit);
    assign hilo_use = ID_ReadsHiLo && (Md_Busy || EX_MdStart);
    assign stall    = load_use || hilo_use;

    always_comb begin
        ctrl = CTRL_RUN;
        if (Reset) begin
            ctrl = CTRL_RESET;
        end else begin
            unique case (1'b1)
                EX_BranchTkn:                      ctrl = CTRL_BRANCH;
                !EX_BranchTkn && stall:            ctrl = CTRL_STALL;
                !EX_BranchTkn && !stall && ID_Jump: ctrl = CTRL_JUMP;
                default:                           ctrl = CTRL_RUN;
            endcase
        end
    end

    assign PC_Write    = ctrl.pc_write;
    assign IF_ID_Write = ctrl.if_id_write;
    assign IF_ID_Flush = ctrl.if_id_flush;
    assign ID_EX_Flush = ctrl.id_ex_flush;

    always_ff @(posedge clk) begin
        if (Reset) begin
            Stall_Cnt <= '0;
        end else if (!ctrl.pc_write && !(&Stall_Cnt)) begin
            Stall_Cnt <= Stall_Cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: reset, load-use, HI/LO stalls,
// mult/div restart and branch/jump priority with hand-computed vectors.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        Reset;
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic        ID_UsesRs;
    logic        ID_UsesRt;
    logic        ID_ReadsHiLo;
    logic        ID_Jump;
    logic        EX_MemtoReg;
    logic [4:0]  EX_Rt;
    logic        EX_BranchTkn;
    logic        EX_MdStart;
    logic        EX_MdIsDiv;
    logic        PC_Write;
    logic        IF_ID_Write;
    logic        IF_ID_Flush;
    logic        ID_EX_Flush;
    logic        Md_Busy;
    logic [31:0] Stall_Cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(
        .MULT_LAT (4),
        .DIV_LAT  (32),
        .CNT_W    (32)
    ) dut (
        .clk          (clk),
        .Reset        (Reset),
        .ID_Rs        (ID_Rs),
        .ID_Rt        (ID_Rt),
        .ID_UsesRs    (ID_UsesRs),
        .ID_UsesRt    (ID_UsesRt),
        .ID_ReadsHiLo (ID_ReadsHiLo),
        .ID_Jump      (ID_Jump),
        .EX_MemtoReg  (EX_MemtoReg),
        .EX_Rt        (EX_Rt),
        .EX_BranchTkn (EX_BranchTkn),
        .EX_MdStart   (EX_MdStart),
        .EX_MdIsDiv   (EX_MdIsDiv),
        .PC_Write     (PC_Write),
        .IF_ID_Write  (IF_ID_Write),
        .IF_ID_Flush  (IF_ID_Flush),
        .ID_EX_Flush  (ID_EX_Flush),
        .Md_Busy      (Md_Busy),
        .Stall_Cnt    (Stall_Cnt)
    );

    // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}
    localparam logic [3:0] C_RST = 4'b0011;
    localparam logic [3:0] C_RUN = 4'b1100;
    localparam logic [3:0] C_STL = 4'b0001;
    localparam logic [3:0] C_BR  = 4'b1111;
    localparam logic [3:0] C_JMP = 4'b1110;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush},
            {28'd0, exp});
    endtask

    task automatic clear_in();
        ID_Rs        = 5'd0;
        ID_Rt        = 5'd0;
        ID_UsesRs    = 1'b0;
        ID_UsesRt    = 1'b0;
        ID_ReadsHiLo = 1'b0;
        ID_Jump      = 1'b0;
        EX_MemtoReg  = 1'b0;
        EX_Rt        = 5'd0;
        EX_BranchTkn = 1'b0;
        EX_MdStart   = 1'b0;
        EX_MdIsDiv   = 1'b0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        Reset = 1'b1;
        clear_in();
        adv();
        adv();
        settle();
        chk_ctrl("init_rst_ctrl", C_RST);
        chk("init_rst_busy", {31'd0, Md_Busy}, 32'd0);
        chk("init_rst_cnt", Stall_Cnt, 32'd0);
        adv();

        Reset = 1'b0;
        settle();
        chk_ctrl("idle_ctrl", C_RUN);
        chk("idle_cnt", Stall_Cnt, 32'd0);
        adv();

        // DIV issue, then MFLO stalls twice before a mid-op reset
        EX_MdStart = 1'b1;
        EX_MdIsDiv = 1'b1;
        settle();
        chk("div_issue_busy", {31'd0, Md_Busy}, 32'd0);
        adv();
        clear_in();
        ID_ReadsHiLo = 1'b1;
        settle();
        chk_ctrl("div_mflo_stall0", C_STL);
        chk("div_busy", {31'd0, Md_Busy}, 32'd1);
        adv();
        settle();
        chk_ctrl("div_mflo_stall1", C_STL);
        adv();
        clear_in();
        settle();
        chk("pre_rst_cnt", Stall_Cnt, 32'd2);
        chk_ctrl("pre_rst_ctrl", C_RUN);

        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk_ctrl("mid_rst_ctrl", C_RST);
            chk("mid_rst_busy", {31'd0, Md_Busy}, 32'd0);
            adv();
        end
        Reset = 1'b0;
        settle();
        chk("post_rst_busy", {31'd0, Md_Busy}, 32'd0);
        chk("post_rst_cnt", Stall_Cnt, 32'd0);
        chk_ctrl("post_rst_ctrl", C_RUN);
        adv();

        // LW $5 in EX, ADD $2,$5,$3 in ID
        EX_MemtoReg = 1'b1;
        EX_Rt       = 5'd5;
        ID_Rs       = 5'd5;
        ID_Rt       = 5'd3;
        ID_UsesRs   = 1'b1;
        ID_UsesRt   = 1'b1;
        settle();
        chk_ctrl("lu_rs_stall", C_STL);
        adv();
        EX_MemtoReg = 1'b0;
        settle();
        chk_ctrl("lu_release", C_RUN);
        chk("lu_cnt", Stall_Cnt, 32'd1);
        adv();

        EX_MemtoReg = 1'b1;
        EX_Rt       = 5'd0;
        ID_Rs       = 5'd0;
        ID_UsesRs   = 1'b1;
        settle();
        chk_ctrl("lu_reg0", C_RUN);
        adv();
        EX_Rt     = 5'd5;
        ID_Rs     = 5'd5;
        ID_UsesRs = 1'b0;
        ID_Rt     = 5'd3;
        ID_UsesRt = 1'b1;
        settle();
        chk_ctrl("lu_rs_unused", C_RUN);
        adv();
        ID_Rt = 5'd5;
        settle();
        chk_ctrl("lu_rt_stall", C_STL);
        adv();
        clear_in();
        settle();
        chk("lu_cnt2", Stall_Cnt, 32'd2);
        adv();

        // MULT then MFLO: stalls for exactly 4 cycles
        EX_MdStart = 1'b1;
        settle();
        chk_ctrl("mult_issue", C_RUN);
        adv();
        clear_in();
        ID_ReadsHiLo = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk_ctrl("mult_stall", C_STL);
            adv();
        end
        settle();
        chk_ctrl("mult_release", C_RUN);
        chk("mult_idle", {31'd0, Md_Busy}, 32'd0);
        chk("mult_cnt", Stall_Cnt, 32'd6);

        // MFLO alongside a fresh issue from EX stalls too
        EX_MdStart = 1'b1;
        #3;
        chk_ctrl("hilo_start_stall", C_STL);
        adv();
        clear_in();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("mult2_busy", {31'd0, Md_Busy}, 32'd1);
            adv();
        end
        settle();
        chk("mult2_idle", {31'd0, Md_Busy}, 32'd0);
        chk("hilo_start_cnt", Stall_Cnt, 32'd7);
        adv();

        // DIV, re-issued 10 cycles later: 32 more busy cycles
        EX_MdStart = 1'b1;
        EX_MdIsDiv = 1'b1;
        adv();
        clear_in();
        for (int i = 0; i < 9; i++) adv();
        EX_MdStart = 1'b1;
        EX_MdIsDiv = 1'b1;
        settle();
        chk("div_reissue_busy", {31'd0, Md_Busy}, 32'd1);
        adv();
        clear_in();
        for (int i = 0; i < 32; i++) begin
            settle();
            chk("div_restart_busy", {31'd0, Md_Busy}, 32'd1);
            adv();
        end
        settle();
        chk("div_restart_idle", {31'd0, Md_Busy}, 32'd0);
        adv();

        // Branch beats load-use and jump
        EX_BranchTkn = 1'b1;
        EX_MemtoReg  = 1'b1;
        EX_Rt        = 5'd7;
        ID_Rs        = 5'd7;
        ID_UsesRs    = 1'b1;
        ID_Jump      = 1'b1;
        settle();
        chk_ctrl("br_priority", C_BR);
        adv();
        clear_in();
        ID_Jump = 1'b1;
        settle();
        chk_ctrl("jump_only", C_JMP);
        adv();
        EX_MemtoReg = 1'b1;
        EX_Rt       = 5'd7;
        ID_Rs       = 5'd7;
        ID_UsesRs   = 1'b1;
        settle();
        chk_ctrl("stall_over_jump", C_STL);
        adv();
        clear_in();
        EX_BranchTkn = 1'b1;
        EX_MdStart   = 1'b1;
        settle();
        chk_ctrl("br_md_ctrl", C_BR);
        adv();
        clear_in();
        settle();
        chk("br_md_busy", {31'd0, Md_Busy}, 32'd1);
        chk("final_cnt", Stall_Cnt, 32'd8);
        adv();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
